// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one sprite's ROM image into the back frame buffer, skipping transparent/off-screen pixels.
// Optional horizontal mirroring is compiled in with `define SPRITE_FLIP_EN.
module sprite_blitter #(
  parameter int SPRITE_W  = 24,
  parameter int SPRITE_H  = 45,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PIX_BITS  = 5,
  parameter int ROM_ABITS = 11,
  parameter int FB_ABITS  = 19
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [9:0]           spriteX,
  input  logic [9:0]           spriteY,
  input  logic                 flipH,
  output logic                 busy,
  output logic                 done,
  output logic [ROM_ABITS-1:0] romAddr,
  input  logic [PIX_BITS-1:0]  romData,
  output logic [FB_ABITS-1:0]  fbAddr,
  output logic [PIX_BITS-1:0]  fbData,
  output logic                 fbWe,
  input  logic                 fbReady
);

  localparam int COL_BITS = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_BITS = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} state_t;

  state_t              state, nextState;
  logic [9:0]          xLat, yLat;
  logic [COL_BITS-1:0] col, nCol;
  logic [ROW_BITS-1:0] row, nRow;
  logic                skip;
  logic                advance, lastPix;
  logic [10:0]         sx, sy;

`ifdef SPRITE_FLIP_EN
  logic flipLat;

  function automatic logic [ROM_ABITS-1:0] romIndex(input logic [ROW_BITS-1:0] r,
                                                    input logic [COL_BITS-1:0] c,
                                                    input logic f);
    logic [COL_BITS-1:0] cc;
    cc = f ? (COL_BITS'(SPRITE_W - 1) - c) : c;
    return ROM_ABITS'(32'(r) * SPRITE_W + 32'(cc));
  endfunction
`else
  logic unusedFlip;
  assign unusedFlip = flipH;

  function automatic logic [ROM_ABITS-1:0] romIndex(input logic [ROW_BITS-1:0] r,
                                                    input logic [COL_BITS-1:0] c);
    return ROM_ABITS'(32'(r) * SPRITE_W + 32'(c));
  endfunction
`endif

  assign lastPix = (row == ROW_BITS'(SPRITE_H - 1)) && (col == COL_BITS'(SPRITE_W - 1));
  assign advance = (state == WRITE) && (skip || fbReady);
  assign nCol    = (col == COL_BITS'(SPRITE_W - 1)) ? '0 : col + 1'b1;
  assign nRow    = (col == COL_BITS'(SPRITE_W - 1)) ? row + 1'b1 : row;
  assign sx      = {1'b0, xLat} + 11'(col);
  assign sy      = {1'b0, yLat} + 11'(row);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = FETCH;
      FETCH:   nextState = CAPTURE;
      CAPTURE: nextState = WRITE;
      WRITE:   if (advance) nextState = lastPix ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FETCH) || (state == CAPTURE) || (state == WRITE);
    done = (state == DONE);
    fbWe = (state == WRITE) && !skip;
  end

  // romAddr is loaded on entry to FETCH so the registered ROM returns data in CAPTURE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      xLat    <= '0;
      yLat    <= '0;
      row     <= '0;
      col     <= '0;
      skip    <= 1'b0;
      romAddr <= '0;
      fbAddr  <= '0;
      fbData  <= '0;
`ifdef SPRITE_FLIP_EN
      flipLat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          xLat <= spriteX;
          yLat <= spriteY;
          row  <= '0;
          col  <= '0;
`ifdef SPRITE_FLIP_EN
          flipLat <= flipH;
          romAddr <= romIndex('0, '0, flipH);
`else
          romAddr <= romIndex('0, '0);
`endif
        end
        CAPTURE: begin
          fbData <= romData;
          fbAddr <= FB_ABITS'(32'(sy) * SCREEN_W + 32'(sx));
          skip   <= (romData == '0) || (sx >= 11'(SCREEN_W)) || (sy >= 11'(SCREEN_H));
        end
        WRITE: if (advance && !lastPix) begin
          row <= nRow;
          col <= nCol;
`ifdef SPRITE_FLIP_EN
          romAddr <= romIndex(nRow, nCol, flipLat);
`else
          romAddr <= romIndex(nRow, nCol);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a pixel-level reference model queues expected writes, a monitor checks them.
module tb_sprite_blitter;

  localparam int SW = 24, SH = 45, SCW = 640, SCH = 480;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, start, flipH, busy, done, fbWe, fbReady;
  logic [9:0]  spriteX, spriteY;
  logic [10:0] romAddr;
  logic [4:0]  romData, fbData;
  logic [18:0] fbAddr;

  sprite_blitter #(
    .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(SCW), .SCREEN_H(SCH),
    .PIX_BITS(5), .ROM_ABITS(11), .FB_ABITS(19)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .spriteX(spriteX), .spriteY(spriteY),
    .flipH(flipH), .busy(busy), .done(done), .romAddr(romAddr), .romData(romData),
    .fbAddr(fbAddr), .fbData(fbData), .fbWe(fbWe), .fbReady(fbReady)
  );

  always #5 Clk = ~Clk;

  logic [4:0] rom [0:2047];
  always @(posedge Clk) romData <= rom[romAddr];

  typedef struct { int addr; int data; } wr_t;
  wr_t sb[$];

  int total = 0, bad = 0;
  int writesAcc = 0;
  int readyMode = 0;
  int stallLeft = 0;
  bit held = 1'b0;
  logic [18:0] hAddr;
  logic [4:0]  hData;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Arbiter model: fbReady changes just after the clock edge.
  initial begin
    fbReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (readyMode == 0) fbReady = 1'b1;
      else                fbReady = ($urandom_range(0, 3) != 0);
      if (stallLeft > 0 && fbWe) begin
        fbReady = 1'b0;
        stallLeft--;
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset) held = 1'b0;
    else begin
      if (held) begin
        chk("stall fbWe held", fbWe, 1);
        chk("stall fbAddr held", fbAddr, hAddr);
        chk("stall fbData held", fbData, hData);
      end
      held = fbWe && !fbReady;
      hAddr = fbAddr;
      hData = fbData;
      if (fbWe && fbReady) begin
        writesAcc++;
        if (sb.size() == 0) chk("unexpected write addr", fbAddr, -1);
        else begin
          wr_t e;
          e = sb.pop_front();
          chk("write addr", fbAddr, e.addr);
          chk("write data", fbData, e.data);
        end
      end
    end
  end

  // Expected writes straight from the pixel rules: row-major, skip code 0 and off-screen.
  task automatic model(input int x, input int y, input bit f);
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        int src, px, py;
        src = r * SW + ((FLIP_EN && f) ? (SW - 1 - c) : c);
        px = x + c;
        py = y + r;
        if (rom[src] != 0 && px < SCW && py < SCH) sb.push_back('{py * SCW + px, int'(rom[src])});
      end
  endtask

  task automatic runBlit(input int x, input int y, input bit f, input int rdy,
                         input int stallN, input bit poke, input int abortAt);
    int busyCnt = 0, stalls = 0, doneSeen = 0, doneCnt = 0;
    bit aborted = 1'b0;
    sb.delete();
    model(x, y, f);
    writesAcc = 0;
    readyMode = rdy;
    stallLeft = stallN;
    spriteX = 10'(x);
    spriteY = 10'(y);
    flipH = f;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge Clk);
      if (busy) busyCnt++;
      if (fbWe && !fbReady) stalls++;
      if (done) begin
        doneSeen = 1;
        break;
      end
      if (poke && busyCnt == 10) begin
        start = 1'b1;
        spriteX = 10'd7;
        spriteY = 10'd3;
      end
      if (abortAt > 0 && writesAcc >= abortAt) begin
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort fbWe", fbWe, 0);
        chk("abort done", done, 0);
        sb.delete();
        for (int k = 0; k < 40; k++) begin
          @(negedge Clk);
          if (done || busy) doneCnt++;
        end
        chk("abort stays idle", doneCnt, 0);
        step();
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("done seen", doneSeen, 1);
      chk("busy cycles", busyCnt, 3 * SW * SH + stalls);
      if (stallN > 0 && rdy == 0) chk("stall cycles", stalls, stallN);
      chk("pending writes", sb.size(), 0);
      chk("done busy low", busy, 0);
      @(posedge Clk);
      #1;
      start = 1'b0;
      @(negedge Clk);
      chk("done one cycle", done, 0);
      chk("no restart busy", busy, 0);
      step();
      chk("start in DONE ignored", busy, 0);
    end
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    spriteX = '0;
    spriteY = '0;
    flipH = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    repeat (3) step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fbWe", fbWe, 0);
    chk("reset romAddr", romAddr, 0);
    chk("reset fbAddr", fbAddr, 0);
    chk("reset fbData", fbData, 0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 2048; i++) rom[i] = 5'h1F;
    runBlit(100, 50, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rom[0] = 5'h03;
    runBlit(0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 2048; i++) rom[i] = 5'h1F;
    runBlit(630, 470, 0, 1, 0, 0, 0);

    for (int i = 0; i < 2048; i++) rom[i] = 5'($urandom);
    runBlit(200, 100, 0, 0, 5, 0, 0);
    runBlit(50, 60, 0, 1, 0, 1, 0);
    runBlit(10, 10, 0, 1, 0, 0, 500);
    runBlit(300, 200, 0, 1, 0, 0, 0);

    for (int i = 0; i < 2048; i++) rom[i] = 5'(i);
    runBlit(0, 0, 1, 1, 0, 0, 0);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2048; i++) rom[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      runBlit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              1'($urandom), 1, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
